aes_round_iter: RTL and testbench

AES_ROUND_ITER -- requirements
Module: aes_round_iter

---
 rtl/aes_round_iter.sv | 154 +++++++++++++++
 tb/tb_aes_round_iter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_iter.sv
// Iterative AES encryption core: one block in flight, ROUNDS_PER_CYCLE rounds per clock.
// Optional define AES_ROUND_ITER_FLUSH_EN adds a synchronous flush input.
module aes_round_iter #(
  parameter int NUM_ROUNDS       = 10,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef AES_ROUND_ITER_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic [128*(NUM_ROUNDS+1)-1:0]   key,
  input  logic [127:0]                    in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [127:0]                    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_nr
    $fatal(1, "aes_round_iter: NUM_ROUNDS must be 10, 12 or 14");
  end
  if ((ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) ||
      (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $fatal(1, "aes_round_iter: ROUNDS_PER_CYCLE must be 1 or 2 and divide NUM_ROUNDS");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse x^254 (square-and-multiply) plus the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Byte i of the state sits at bits [127-8*i -: 8]; byte index = row + 4*column
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] od_q, od_d;
  logic [127:0] rnd_s;
  logic         fin;

  always_comb begin
    rnd_s = st_q;
    fin   = 1'b0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      rnd_s = aes_round(rnd_s, key[128*(int'(cnt_q)+r) +: 128],
                        (int'(cnt_q) + r) == NUM_ROUNDS);
      if ((int'(cnt_q) + r) == NUM_ROUNDS) fin = 1'b1;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    od_d  = od_q;
    case (fsm_q)
      S_IDLE: if (in_valid) begin
        st_d  = in_data ^ key[127:0];
        cnt_d = 4'd1;
        fsm_d = S_RUN;
      end
      S_RUN: begin
        st_d = rnd_s;
        if (fin) begin
          od_d  = rnd_s;
          cnt_d = '0;
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'(ROUNDS_PER_CYCLE);
        end
      end
      S_DONE: if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
`ifdef AES_ROUND_ITER_FLUSH_EN
    if (flush) begin
      fsm_d = S_IDLE;
      cnt_d = '0;
      st_d  = '0;
      od_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      st_q  <= '0;
      od_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
      od_q  <= od_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q == S_RUN);
  assign out_valid = (fsm_q == S_DONE);
  assign out_data  = od_q;

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: three instances (AES-128/1, AES-192/2, AES-256/1) driven in
// lockstep and checked against a byte-level software AES model.
module tb_aes_round_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [127:0]         in_data;
  logic                 in_valid, out_ready;
  logic [128*11-1:0]    key10;
  logic [128*13-1:0]    key12;
  logic [128*15-1:0]    key14;
  logic [2:0]           ir, ov, bz;
  logic [127:0]         od [3];
  logic [127:0]         ex [3];
`ifdef AES_ROUND_ITER_FLUSH_EN
  logic                 flush;
`endif

  int nvec = 0;
  int nerr = 0;

  aes_round_iter #(.NUM_ROUNDS(10), .ROUNDS_PER_CYCLE(1)) u_dut10 (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_ITER_FLUSH_EN
    .flush(flush),
`endif
    .key(key10), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]));

  aes_round_iter #(.NUM_ROUNDS(12), .ROUNDS_PER_CYCLE(2)) u_dut12 (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_ITER_FLUSH_EN
    .flush(flush),
`endif
    .key(key12), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]));

  aes_round_iter #(.NUM_ROUNDS(14), .ROUNDS_PER_CYCLE(1)) u_dut14 (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_ITER_FLUSH_EN
    .flush(flush),
`endif
    .key(key14), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // inverse found by exhaustive search, then the FIPS-197 affine transform
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [128*15-1:0] expand(input logic [255:0] k, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [128*15-1:0] ek;
    rc = 8'h01;
    ek = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] d, input logic [128*15-1:0] ek,
                                           input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8] ^ ek[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[128*rnd + 127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] d, input logic [255:0] k);
    logic [128*15-1:0] t;
    in_data = d;
    t = expand(k, 4, 10); key10 = t[128*11-1:0]; ex[0] = encrypt(d, t, 10);
    t = expand(k, 6, 12); key12 = t[128*13-1:0]; ex[1] = encrypt(d, t, 12);
    t = expand(k, 8, 14); key14 = t;             ex[2] = encrypt(d, t, 14);
  endtask

  task automatic wait_done(input string tag);
    int lat [3];
    lat = '{-1, -1, -1};
    for (int k = 1; k <= 16; k++) begin
      tick();
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] < 0) lat[d] = k;
    end
    chk({tag, "_lat10"}, 128'(lat[0]), 128'd10);
    chk({tag, "_lat12"}, 128'(lat[1]), 128'd6);
    chk({tag, "_lat14"}, 128'(lat[2]), 128'd14);
    for (int d = 0; d < 3; d++) chk({tag, "_data"}, od[d], ex[d]);
  endtask

  task automatic run_block(input string tag, input bit bp);
    chk({tag, "_ready_idle"}, 128'(ir), 128'h7);
    in_valid = 1'b1;
    tick();
    if (!bp) in_valid = 1'b0;
    chk({tag, "_busy"}, 128'(bz), 128'h7);
    chk({tag, "_ready_run"}, 128'(ir), 128'h0);
    wait_done(tag);
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        for (int d = 0; d < 3; d++) chk({tag, "_bp_hold"}, od[d], ex[d]);
        chk({tag, "_bp_ready"}, 128'(ir), 128'h0);
        chk({tag, "_bp_valid"}, 128'(ov), 128'h7);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 128'(ov), 128'h0);
    chk({tag, "_ready_back"}, 128'(ir), 128'h7);
    chk({tag, "_busy_clr"}, 128'(bz), 128'h0);
    for (int d = 0; d < 3; d++) chk({tag, "_retain"}, od[d], ex[d]);
    if (bp) begin
      tick();
      in_valid = 1'b0;
      chk({tag, "_reaccept"}, 128'(bz), 128'h7);
      wait_done({tag, "_re"});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_re_idle"}, 128'(ir), 128'h7);
    end
  endtask

  logic [255:0] kat_key;
  logic [255:0] rk;
  logic [127:0] rd;
  logic [2:0]   seen;

  initial begin
    build_sbox();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    key10 = '0; key12 = '0; key14 = '0;
`ifdef AES_ROUND_ITER_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    chk("rst_valid", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    chk("rst_ready", 128'(ir), 128'h7);
    for (int d = 0; d < 3; d++) chk("rst_data", od[d], 128'h0);
    #1 rst = 1'b1;

    // known-answer vectors; DUT compared against published ciphertexts
    kat_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    load(128'h00112233445566778899aabbccddeeff, kat_key);
    ex[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ex[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ex[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    run_block("kat", 1'b0);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      load(rd, rk);
      run_block("rnd", n == 1);
    end

    // reset in the middle of a block
    load({$urandom, $urandom, $urandom, $urandom}, kat_key);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 128'(ov), 128'h0);
    chk("midrst_busy", 128'(bz), 128'h0);
    chk("midrst_ready", 128'(ir), 128'h7);
    for (int d = 0; d < 3; d++) chk("midrst_data", od[d], 128'h0);
    #1 rst = 1'b1;
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      seen = seen | ov | ~ir;
    end
    chk("midrst_quiet", 128'(seen), 128'h0);
    run_block("post_rst", 1'b0);

`ifdef AES_ROUND_ITER_FLUSH_EN
    load({$urandom, $urandom, $urandom, $urandom}, kat_key);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_run_valid", 128'(ov), 128'h0);
    chk("flush_run_ready", 128'(ir), 128'h7);
    for (int d = 0; d < 3; d++) chk("flush_run_data", od[d], 128'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("flush_pre");
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b0;
    chk("flush_done_valid", 128'(ov), 128'h0);
    chk("flush_done_ready", 128'(ir), 128'h7);
    for (int d = 0; d < 3; d++) chk("flush_done_data", od[d], 128'h0);
    run_block("post_flush", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
